// File: rtl/ascii_hex_parser32_if.sv
// Character-in / word-out handshake bundle for ascii_hex_parser32.
// slave = parser side, master = character source plus word consumer.
interface ascii_hex_parser32_if;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        error;
  logic [3:0]  col;

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready,
    output word_out,
    output word_valid,
    input  word_ready,
    output error,
    output col
  );

  modport master (
    output char_in,
    output char_valid,
    input  char_ready,
    input  word_out,
    input  word_valid,
    output word_ready,
    input  error,
    input  col
  );
endinterface

// File: rtl/ascii_hex_parser32.sv
// Parses "HH-HH-HH-HH" ASCII text into a 32-bit word with valid/ready out.
// Define ASCII_HEX_LOWERCASE_EN to also accept 'a'..'f' as digits.
module ascii_hex_parser32 #(
  parameter logic [6:0] SEPARATOR = 7'h2D
) (
  input  logic              clk,
  input  logic              rst,
  ascii_hex_parser32_if.slave bus
);

  localparam int          WORD_CHARS = 11;
  localparam logic [3:0]  LAST_COL   = 4'(WORD_CHARS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [3:0]  col, col_n;
  logic [27:0] acc, acc_n;
  logic [31:0] word_q, word_n;
  logic        wvalid_q, wvalid_n;
  logic        err_q, err_n;

  logic        dig_ok;
  logic [3:0]  nib;
  logic        is_dig_col;
  logic        is_sep_col;
  logic        legal;

  // Decode the incoming character into a nibble, flagging non-hex codes.
  always_comb begin
    dig_ok = 1'b0;
    nib    = 4'h0;
    unique case (1'b1)
      (bus.char_in >= 7'h30 && bus.char_in <= 7'h39): begin
        dig_ok = 1'b1;
        nib    = 4'(bus.char_in - 7'd48);
      end
      (bus.char_in >= 7'h41 && bus.char_in <= 7'h46): begin
        dig_ok = 1'b1;
        nib    = 4'(bus.char_in - 7'd55);
      end
`ifdef ASCII_HEX_LOWERCASE_EN
      (bus.char_in >= 7'h61 && bus.char_in <= 7'h66): begin
        dig_ok = 1'b1;
        nib    = 4'(bus.char_in - 7'd87);
      end
`else
`endif
      default: ;
    endcase
  end

  // Classify the current column; 11..15 is neither kind, so always illegal.
  always_comb begin
    is_dig_col = 1'b0;
    is_sep_col = 1'b0;
    unique case (col)
      4'd0, 4'd1, 4'd3, 4'd4,
      4'd6, 4'd7, 4'd9, 4'd10: is_dig_col = 1'b1;
      4'd2, 4'd5, 4'd8:        is_sep_col = 1'b1;
      default: ;
    endcase
  end

  // A character is legal when it fits the kind of column it lands in.
  always_comb begin
    legal = (is_dig_col && dig_ok) ||
            (is_sep_col && bus.char_in == SEPARATOR);
  end

  // Next-state and datapath update for both FSM states.
  always_comb begin
    state_n  = state;
    col_n    = col;
    acc_n    = acc;
    word_n   = word_q;
    wvalid_n = wvalid_q;
    err_n    = 1'b0;
    unique case (state)
      COLLECT: begin
        if (bus.char_valid) begin
          if (!legal) begin
            err_n = 1'b1;
            col_n = 4'd0;
            acc_n = 28'h0;
          end else if (col == LAST_COL) begin
            word_n   = {acc, nib};
            wvalid_n = 1'b1;
            state_n  = DONE;
            col_n    = 4'd0;
            acc_n    = 28'h0;
          end else begin
            col_n = col + 4'd1;
            if (is_dig_col) acc_n = {acc[23:0], nib};
          end
        end
      end
      DONE: begin
        if (wvalid_q && bus.word_ready) begin
          wvalid_n = 1'b0;
          state_n  = COLLECT;
        end
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      col      <= 4'd0;
      acc      <= 28'h0;
      word_q   <= 32'h0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      acc      <= acc_n;
      word_q   <= word_n;
      wvalid_q <= wvalid_n;
      err_q    <= err_n;
    end
  end

  assign bus.char_ready = (state == COLLECT);
  assign bus.word_out   = word_q;
  assign bus.word_valid = wvalid_q;
  assign bus.error      = err_q;
  assign bus.col        = col;

endmodule

// File: tb/tb_ascii_hex_parser32.sv
// Directed bench for ascii_hex_parser32.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ascii_hex_parser32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ascii_hex_parser32_if bus();

  ascii_hex_parser32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      b = s[i];
      bus.char_valid = 1'b1;
      bus.char_in    = b[6:0];
      @(posedge clk);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.char_in    = 7'h0;
    bus.char_valid = 1'b0;
    bus.word_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_col", 32'(bus.col), 32'd0);
    chk("rst_wv", 32'(bus.word_valid), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);
    chk("rst_rdy", 32'(bus.char_ready), 32'd1);
    chk("rst_word", bus.word_out, 32'h0);

    bus.word_ready = 1'b1;
    send("30-2E-32-76");
    @(negedge clk);
    chk("w1_valid", 32'(bus.word_valid), 32'd1);
    chk("w1_word", bus.word_out, 32'h302E3276);
    chk("w1_col", 32'(bus.col), 32'd0);
    chk("w1_rdy0", 32'(bus.char_ready), 32'd0);
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("w1_drop", 32'(bus.word_valid), 32'd0);
    chk("w1_rdy1", 32'(bus.char_ready), 32'd1);

    bus.word_ready = 1'b0;
    send("DE-AD-BE-EF");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("w2_valid", 32'(bus.word_valid), 32'd1);
      chk("w2_word", bus.word_out, 32'hDEADBEEF);
      chk("w2_rdy0", 32'(bus.char_ready), 32'd0);
      chk("w2_col", 32'(bus.col), 32'd0);
    end
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("w2_drop", 32'(bus.word_valid), 32'd0);
    chk("w2_rdy1", 32'(bus.char_ready), 32'd1);
    chk("w2_keep", bus.word_out, 32'hDEADBEEF);

    send("12-3G");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("g_err", 32'(bus.error), 32'd1);
    chk("g_col", 32'(bus.col), 32'd0);
    chk("g_word", bus.word_out, 32'hDEADBEEF);
    chk("g_wv", 32'(bus.word_valid), 32'd0);
    @(negedge clk);
    chk("g_pulse", 32'(bus.error), 32'd0);
    send("00-00-00-01");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("w3_word", bus.word_out, 32'h00000001);
    chk("w3_valid", 32'(bus.word_valid), 32'd1);
    chk("w3_err", 32'(bus.error), 32'd0);
    @(negedge clk);
    chk("w3_drop", 32'(bus.word_valid), 32'd0);

    send("123");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("sep_err", 32'(bus.error), 32'd1);
    chk("sep_col", 32'(bus.col), 32'd0);
    chk("sep_wv", 32'(bus.word_valid), 32'd0);
    send("4");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("sep_c1", 32'(bus.col), 32'd1);
    chk("sep_e0", 32'(bus.error), 32'd0);
    send("0-00-00-00");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("w4_word", bus.word_out, 32'h40000000);
    chk("w4_valid", 32'(bus.word_valid), 32'd1);
    @(negedge clk);

`ifdef ASCII_HEX_LOWERCASE_EN
    send("ab-cd-ef-01");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("lc_word", bus.word_out, 32'hABCDEF01);
    chk("lc_valid", 32'(bus.word_valid), 32'd1);
    chk("lc_err", 32'(bus.error), 32'd0);
    @(negedge clk);
`else
    send("a");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("lc_err", 32'(bus.error), 32'd1);
    chk("lc_col", 32'(bus.col), 32'd0);
    chk("lc_word", bus.word_out, 32'h40000000);
    chk("lc_wv", 32'(bus.word_valid), 32'd0);
`endif

    send("AB-CD");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("mid_col", 32'(bus.col), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r2_col", 32'(bus.col), 32'd0);
    chk("r2_wv", 32'(bus.word_valid), 32'd0);
    chk("r2_err", 32'(bus.error), 32'd0);
    chk("r2_rdy", 32'(bus.char_ready), 32'd1);
    chk("r2_word", bus.word_out, 32'h0);
    send("11-22-33-44");
    @(negedge clk);
    bus.char_valid = 1'b0;
    chk("w5_word", bus.word_out, 32'h11223344);
    chk("w5_valid", 32'(bus.word_valid), 32'd1);
    chk("w5_err", 32'(bus.error), 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser32.md
Name: ascii_hex_parser32

Overview:
- Receives a stream of 7-bit ASCII characters in the fixed display format HH-HH-HH-HH, for example "30-2E-32-76".
- Rebuilds the 32-bit word those characters describe and presents it through a valid/ready output handshake.
- This is the input-side counterpart of the hex-to-ASCII display path. It sits between a character source (keyboard or UART receiver) and the datapath or debug loader, which consumes 32-bit values.

Parameters:
- SEPARATOR, 7'h2D, ASCII code required at separator columns ("-").
- WORD_CHARS, 11, characters per word: 8 hex digits + 3 separators. Fixed; not for override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- char_in  input  7  ASCII character
- char_valid  input  1  char_in is valid this cycle
- char_ready  output  1  block can accept a character
- word_out  output  32  last completed word
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer takes word_out
- error  output  1  one-cycle pulse: illegal character, partial word discarded
- col  output  4  column expected next (0..10)

Behaviour:
- Reset (sync, rst=1 at a rising edge) forces the following, regardless of state:
  - state=COLLECT
  - col=0, internal accumulator=0
  - word_out=32'h0, word_valid=0, error=0
  - char_ready=1 from the first cycle after reset
- Reset mid-word discards the partial word. No word_valid and no error are produced.
- Character acceptance:
  - A character is accepted on a rising edge where char_valid && char_ready.
  - char_ready is derived from state only (COLLECT=1, DONE=0). It has no combinational path from char_valid.
- Column map:
  - Cols 0,1,3,4,6,7,9,10 are hex digits.
  - Cols 2,5,8 are separators.
  - Digit order is MSB first: col 0 supplies word bits [31:28], col 10 supplies bits [3:0].
- Digit decode:
  - 0x30..0x39 gives value c-48.
  - 0x41..0x46 gives value c-55.
  - Any other code is illegal.
- Accumulation: on each accepted legal digit, acc <= {acc[27:0], nibble}. Separators do not change acc.
- State COLLECT:
  - Legal char at col<10: col increments next cycle.
  - Legal digit at col 10:
    - next cycle: word_out <= {acc[27:0], nibble}, word_valid=1, state=DONE, col=0, acc=0.
    - Latency is 1 cycle from acceptance of the last char to word_valid.
  - Illegal char (non-hex at a digit column, or != SEPARATOR at a separator column):
    - next cycle: error=1 for exactly one cycle, col=0, acc=0, state stays COLLECT.
    - word_out and word_valid are unchanged.
- State DONE:
  - char_ready=0; char_valid is ignored.
  - word_out and word_valid are held stable until word_ready=1.
  - On word_valid && word_ready: next cycle word_valid=0, state=COLLECT, char_ready=1.
  - word_out keeps its last value after consumption.
- Boundary cases:
  - word_ready asserted while word_valid=0 has no effect.
  - error and word_valid are never raised by the same character.
  - col never exceeds 10. If col reaches 11..15 (unreachable), it is treated as illegal and behaves like the error path.

Optional Feature:
- Macro: ASCII_HEX_LOWERCASE_EN
- Defined: 0x61..0x66 ('a'..'f') also decode as legal digits, value c-87. Uppercase decode is unchanged.
- Undefined: lowercase letters are illegal and take the error path.

Test Plan:
- Reset, then send "30-2E-32-76" with char_valid held 1 and word_ready=1:
  - word_valid=1 one cycle after '6' is accepted, word_out=32'h302E3276.
  - col=0 afterwards; char_ready back to 1 the following cycle.
- Send "DE-AD-BE-EF" with word_ready=0 for 5 cycles while char_valid stays 1 with char 'F':
  - word_out=32'hDEADBEEF held and char_ready=0 throughout; no extra chars are consumed.
  - Raise word_ready: word_valid drops next cycle.
- Send "12-3G":
  - error pulses one cycle after 'G', col=0, word_out unchanged.
  - Then send "00-00-00-01": word_out=32'h00000001.
- Send "1234" (no separator): error pulse after the '3' at col 2, col=0, no word_valid.
- Send "ab-cd-ef-01":
  - With ASCII_HEX_LOWERCASE_EN defined: word_out=32'hABCDEF01.
  - Without it: error after 'a' at col 0.
- Accept "AB-CD", assert rst for one cycle, then send "11-22-33-44":
  - After reset: col=0, word_valid=0, error=0.
  - Final word_out=32'h11223344.
